// File: rtl/snn_frame_sequencer_pkg.sv
// Shared state encoding and constants for the SNN frame sequencer and its chunk writer.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } snn_state_e;

  localparam int unsigned DEF_WORD_W          = 32;
  localparam int unsigned DEF_WORDS_PER_CHUNK = 14;
  localparam int unsigned CHUNK_BITS          = DEF_WORD_W * DEF_WORDS_PER_CHUNK;

  localparam int unsigned ERR_OVERRUN = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

endpackage

// File: rtl/snn_frame_sequencer_chunk_writer.sv
// Image register: writes one chunk at offset chunk_idx*CHUNK_W, dropping bits past IMG_BITS,
// and clears the whole image when the first chunk of a frame arrives.
module snn_chunk_writer
  import snn_pkg::*;
#(
  parameter int unsigned CHUNK_W    = CHUNK_BITS,
  parameter int unsigned IMG_BITS   = 800,
  parameter int unsigned MAX_CHUNKS = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic                first_i,
  input  logic [CNT_W-1:0]    chunk_idx_i,
  input  logic [CHUNK_W-1:0]  data_i,
  output logic [IMG_BITS-1:0] image_o
);

  // Wide enough that any legal offset plus a full chunk fits before truncation.
  localparam int unsigned WIDE_W = (MAX_CHUNKS + 1) * CHUNK_W;
  localparam int unsigned PAD_W  = WIDE_W - CHUNK_W;

  logic [IMG_BITS-1:0] image_q, image_d;
  logic [IMG_BITS-1:0] data_img_s, mask_img_s, base_img_s;
  logic [31:0]         shift_s;

  assign shift_s    = 32'(chunk_idx_i) * CHUNK_W;
  assign data_img_s = IMG_BITS'({{PAD_W{1'b0}}, data_i} << shift_s);
  assign mask_img_s = IMG_BITS'({{PAD_W{1'b0}}, {CHUNK_W{1'b1}}} << shift_s);

  // Next image: merge the shifted chunk over either the old image or a cleared one.
  always_comb begin
    base_img_s = image_q;
    image_d    = image_q;
    if (first_i) begin
      base_img_s = {IMG_BITS{1'b0}};
    end else begin
      base_img_s = image_q;
    end
    if (wr_en_i) begin
      image_d = (base_img_s & ~mask_img_s) | (data_img_s & mask_img_s);
    end else begin
      image_d = image_q;
    end
  end

  // Image storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      image_q <= {IMG_BITS{1'b0}};
    end else begin
      image_q <= image_d;
    end
  end

  assign image_o = image_q;

endmodule

// File: rtl/snn_frame_sequencer.sv
// Frame sequencer: gathers mailbox chunks into the image, pulses network start,
// waits for done (bounded by a timeout) and latches the result for the host.
module snn_frame_sequencer
  import snn_pkg::*;
#(
  parameter int unsigned WORD_W          = DEF_WORD_W,
  parameter int unsigned WORDS_PER_CHUNK = DEF_WORDS_PER_CHUNK,
  parameter int unsigned IMG_BITS        = 800,
  parameter int unsigned MAX_CHUNKS      = 2,
  parameter int unsigned OUT_W           = 2,
  parameter int unsigned TIMEOUT_W       = 20
) (
  input  logic                              iCLK,
  input  logic                              iRESETn,
  input  logic                              iNEXT,
  input  logic                              iFINISH,
  input  logic [WORD_W*WORDS_PER_CHUNK-1:0] iDATA,
  output logic [IMG_BITS-1:0]               oIMAGE,
  output logic                              oSTART,
  input  logic                              iSNN_DONE,
  input  logic [OUT_W-1:0]                  iSNN_OUT,
  output logic [OUT_W-1:0]                  oRESULT,
  output logic                              oRESULT_VALID,
  output logic                              oCHUNK_ACK,
  output logic                              oBUSY,
  output logic [1:0]                        oERROR,
  input  logic                              iCLR_ERR
);

  localparam int unsigned CHUNK_W = WORD_W * WORDS_PER_CHUNK;
  localparam int unsigned CNT_W   = $clog2(MAX_CHUNKS + 1);
  localparam logic [CNT_W-1:0]     K_MAX   = CNT_W'(MAX_CHUNKS);
  localparam logic [TIMEOUT_W-1:0] TMO_ALL = {TIMEOUT_W{1'b1}};

  snn_state_e           state_q;
  logic                 next_q, start_q, ack_q, busy_q, rvalid_q;
  logic [CNT_W-1:0]     k_q;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [OUT_W-1:0]     result_q;
  logic [1:0]           err_q, err_set_s;
  logic                 edge_s, loading_s, accept_s, timeout_s, first_s;

  assign edge_s    = iNEXT & ~next_q;
  assign loading_s = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept_s  = edge_s & loading_s & (k_q < K_MAX);
  assign first_s   = (k_q == {CNT_W{1'b0}});
  assign tmo_d     = tmo_q + TIMEOUT_W'(1);
  assign timeout_s = (tmo_d == TMO_ALL);

  // Any edge that is not accepted is an overrun; done in the last cycle beats timeout.
  always_comb begin
    err_set_s              = 2'b00;
    err_set_s[ERR_OVERRUN] = edge_s & ~accept_s;
    err_set_s[ERR_TIMEOUT] = (state_q == ST_RUN) & ~iSNN_DONE & timeout_s;
  end

  // Sequencer FSM with its counters and registered handshake outputs.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q  <= ST_IDLE;
      next_q   <= 1'b0;
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      k_q      <= {CNT_W{1'b0}};
      tmo_q    <= {TIMEOUT_W{1'b0}};
      result_q <= {OUT_W{1'b0}};
      err_q    <= 2'b00;
    end else begin
      next_q  <= iNEXT;
      start_q <= 1'b0;
      ack_q   <= accept_s;
      err_q   <= err_set_s | (iCLR_ERR ? 2'b00 : err_q);
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept_s && first_s) begin
            rvalid_q <= 1'b0;
          end
          if (edge_s && iFINISH) begin
            state_q <= ST_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            k_q     <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            state_q <= ST_LOAD;
            k_q     <= k_q + CNT_W'(1);
          end
        end
        ST_START: begin
          state_q <= ST_RUN;
          tmo_q   <= {TIMEOUT_W{1'b0}};
        end
        ST_RUN: begin
          if (iSNN_DONE) begin
            result_q <= iSNN_OUT;
            rvalid_q <= 1'b1;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            tmo_q    <= {TIMEOUT_W{1'b0}};
          end else if (timeout_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= {TIMEOUT_W{1'b0}};
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  snn_chunk_writer #(
    .CHUNK_W    (CHUNK_W),
    .IMG_BITS   (IMG_BITS),
    .MAX_CHUNKS (MAX_CHUNKS),
    .CNT_W      (CNT_W)
  ) u_writer (
    .clk_i       (iCLK),
    .rst_ni      (iRESETn),
    .wr_en_i     (accept_s),
    .first_i     (first_s),
    .chunk_idx_i (k_q),
    .data_i      (iDATA),
    .image_o     (oIMAGE)
  );

  assign oSTART        = start_q;
  assign oCHUNK_ACK    = ack_q;
  assign oBUSY         = busy_q;
  assign oRESULT       = result_q;
  assign oRESULT_VALID = rvalid_q;
  assign oERROR        = err_q;

endmodule
